// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared types and constants for the data RAM controller
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10
  } ctrl_state_e;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/data_mem_ctrl_rr_arbiter2.sv
// rtl/data_mem_ctrl_rr_arbiter2.sv - two-way round-robin arbiter with one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic rr_last_q;

  // On contention the port not granted last time wins; a lone requester always wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = rr_last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= 1'b1;
    end else if (update && (|req)) begin
      rr_last_q <= grant[1];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - arbitrated data RAM controller with read-modify-write sub-word stores
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    req_valid,
  output logic [NUM_PORTS-1:0]                    req_ready,
  input  logic [NUM_PORTS-1:0]                    req_we,
  input  logic [NUM_PORTS-1:0][1:0]               req_size,
  input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_PORTS-1:0]                    resp_valid,
  output logic [DATA_WIDTH-1:0]                   resp_rdata,
  output logic [ADDRESS_WIDTH-1:0]                Data_addr,
  output logic [DATA_WIDTH-1:0]                   Data_WD,
  output logic                                    Data_WE,
  input  logic [DATA_WIDTH-1:0]                   Data_RD
);

  ctrl_state_e              state_q, state_d;
  logic                     we_q;
  logic [1:0]               size_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     port_q;
  logic [DATA_WIDTH-1:0]    merge_q, merge_d;
  logic [DATA_WIDTH-1:0]    wd_last_q;
  logic [NUM_PORTS-1:0]     grant;
  logic [NUM_PORTS-1:0]     port_oh;
  logic                     is_word;
  logic                     win;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (state_q == IDLE),
    .grant  (grant)
  );

  assign win       = grant[PORT_DMA];
  assign is_word   = size_q[1];
  assign port_oh   = (port_q == PORT_DMA) ? 2'b10 : 2'b01;
  assign Data_addr = addr_q;

  // The RAM is big-endian, so the addressed byte/half lands in the top bits of the word.
  assign merge_d = (size_q == SZ_BYTE)
                 ? {wdata_q[7:0],  Data_RD[DATA_WIDTH-9:0]}
                 : {wdata_q[15:0], Data_RD[DATA_WIDTH-17:0]};

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    Data_WE    = 1'b0;
    Data_WD    = wd_last_q;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          resp_valid = port_oh;
          resp_rdata = Data_RD;
          state_d    = IDLE;
        end else if (is_word) begin
          Data_WE    = 1'b1;
          Data_WD    = wdata_q;
          resp_valid = port_oh;
          state_d    = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        Data_WE    = 1'b1;
        Data_WD    = merge_q;
        resp_valid = port_oh;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      port_q    <= PORT_CPU;
      merge_q   <= '0;
      wd_last_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (|req_valid)) begin
        we_q    <= req_we[win];
        size_q  <= req_size[win];
        addr_q  <= req_addr[win];
        wdata_q <= req_wdata[win];
        port_q  <= win;
      end
      if ((state_q == ACCESS) && we_q && !is_word) merge_q <= merge_d;
      // Data_WD keeps its last driven value while idle.
      if (Data_WE) wd_last_q <= Data_WD;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, resp_valid;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [31:0]      resp_rdata, Data_addr, Data_WD, Data_RD;
  logic             Data_WE;

  logic [7:0] mem [256];
  logic [7:0] a0, a1, a2, a3;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .Data_addr  (Data_addr),
    .Data_WD    (Data_WD),
    .Data_WE    (Data_WE),
    .Data_RD    (Data_RD)
  );

  // Big-endian 256-byte RAM model with address wrap.
  assign a0 = Data_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  assign Data_RD = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always @(posedge clk) begin
    if (Data_WE) begin
      mem[a0] = Data_WD[31:24];
      mem[a1] = Data_WD[23:16];
      mem[a2] = Data_WD[15:8];
      mem[a3] = Data_WD[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    mem[a]        = d[31:24];
    mem[a + 8'd1] = d[23:16];
    mem[a + 8'd2] = d[15:8];
    mem[a + 8'd3] = d[7:0];
  endtask

  function automatic logic [31:0] peek(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic drive(input int p, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_we[p]    = we;
    req_size[p]  = sz;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
    req_valid[p] = 1'b1;
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    step();
    step();
    chk("rst_ready",  {30'd0, req_ready},  32'd0);
    chk("rst_resp",   {30'd0, resp_valid}, 32'd0);
    chk("rst_rdata",  resp_rdata,          32'd0);
    chk("rst_we",     {31'd0, Data_WE},    32'd0);
    chk("rst_addr",   Data_addr,           32'd0);
    chk("rst_wd",     Data_WD,             32'd0);
    rst_n = 1'b1;

    // Word store then load on port 0
    drive(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    #1 chk("ws_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    chk("ws_resp",  {30'd0, resp_valid}, 32'd1);
    chk("ws_we",    {31'd0, Data_WE},    32'd1);
    chk("ws_addr",  Data_addr,           32'h10);
    chk("ws_wd",    Data_WD,             32'hDEADBEEF);
    chk("ws_noacc", {30'd0, req_ready},  32'd0);
    step();
    chk("ws_ram",   peek(8'h10),         32'hDEADBEEF);
    chk("ws_idle",  {31'd0, Data_WE},    32'd0);
    drive(0, 1'b0, 2'b10, 32'h10, 32'h0);
    #1 chk("ld_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    chk("ld_resp",  {30'd0, resp_valid}, 32'd1);
    chk("ld_rdata", resp_rdata,          32'hDEADBEEF);
    chk("ld_we",    {31'd0, Data_WE},    32'd0);
    step();

    // Byte store read-modify-write on port 1
    preload(8'h20, 32'h11223344);
    drive(1, 1'b1, 2'b00, 32'h20, 32'h000000AA);
    #1 chk("bs_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = '0;
    chk("bs_acc_we",   {31'd0, Data_WE},    32'd0);
    chk("bs_acc_resp", {30'd0, resp_valid}, 32'd0);
    chk("bs_acc_addr", Data_addr,           32'h20);
    step();
    chk("bs_wr_we",   {31'd0, Data_WE},    32'd1);
    chk("bs_wr_wd",   Data_WD,             32'hAA223344);
    chk("bs_wr_resp", {30'd0, resp_valid}, 32'd2);
    step();
    chk("bs_ram",     peek(8'h20),         32'hAA223344);
    chk("bs_wd_hold", Data_WD,             32'hAA223344);

    // Half store on port 1, then load back
    preload(8'h40, 32'h11223344);
    drive(1, 1'b1, 2'b01, 32'h40, 32'h0000BEEF);
    #1 chk("hs_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = '0;
    step();
    chk("hs_wd", Data_WD, 32'hBEEF3344);
    step();
    drive(1, 1'b0, 2'b10, 32'h40, 32'h0);
    #1 chk("hl_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = '0;
    chk("hl_resp",  {30'd0, resp_valid}, 32'd2);
    chk("hl_rdata", resp_rdata,          32'hBEEF3344);
    step();

    // Contention: both ports hold loads for six accepts
    drive(0, 1'b0, 2'b10, 32'h10, 32'h0);
    drive(1, 1'b0, 2'b11, 32'h40, 32'h0);
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'hDEADBEEF : 32'hBEEF3344;
      #1 chk($sformatf("ct_grant%0d", i), {30'd0, req_ready}, {30'd0, exp_g});
      step();
      chk($sformatf("ct_resp%0d", i),  {30'd0, resp_valid}, {30'd0, exp_g});
      chk($sformatf("ct_rdata%0d", i), resp_rdata,          exp_d);
      chk($sformatf("ct_busy%0d", i),  {30'd0, req_ready},  32'd0);
      step();
    end
    req_valid = '0;

    // Wrap-around word store
    drive(0, 1'b1, 2'b10, 32'hFE, 32'hCAFEF00D);
    #1 chk("wr_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    step();
    chk("wr_ram", {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]}, 32'hCAFEF00D);

    // Reset during the WRITE phase of a byte store
    preload(8'h30, 32'h01020304);
    drive(0, 1'b1, 2'b00, 32'h30, 32'h00000055);
    #1 chk("rw_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    chk("rw_acc_we", {31'd0, Data_WE}, 32'd0);
    step();
    chk("rw_wr_we", {31'd0, Data_WE}, 32'd1);
    chk("rw_wr_wd", Data_WD,          32'h55020304);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_we",   {31'd0, Data_WE},    32'd0);
    chk("rw_rst_resp", {30'd0, resp_valid}, 32'd0);
    step();
    chk("rw_ram",       peek(8'h30),         32'h01020304);
    chk("rw_rst_resp2", {30'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    drive(0, 1'b0, 2'b10, 32'h30, 32'h0);
    drive(1, 1'b0, 2'b10, 32'h40, 32'h0);
    #1 chk("rw_prio", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = '0;
    chk("rw_ld_resp",  {30'd0, resp_valid}, 32'd1);
    chk("rw_ld_rdata", resp_rdata,          32'h01020304);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
